// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - RV32I decode stage: register file, immediate/control decode, load-use stall, ID/EX register
module decode_unit #(
    parameter int PC_W = 16,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [PC_W-1:0] if_pc,
    input  logic [31:0]     if_inst,
    input  logic            if_dne,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            stall,
    output logic [PC_W-1:0] id_pc,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_branch,
    output logic            id_jump,
    output logic            id_alu_imm,
    output logic            id_illegal,
    output logic            id_dne
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        legal;
    logic        fmt_r, fmt_s, fmt_b, fmt_u, fmt_j;
    logic        c_reg_write, c_mem_read, c_mem_write, c_branch, c_jump, c_alu_imm;
    logic        rs1_used, rs2_used;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign opcode = if_inst[6:0];
    assign rd     = if_inst[11:7];
    assign rs1    = if_inst[19:15];
    assign rs2    = if_inst[24:20];

    // Opcode decode: format, immediate and control bits for the instruction in IF/ID
    always_comb begin
        imm         = '0;
        legal       = 1'b0;
        fmt_r       = 1'b0;
        fmt_s       = 1'b0;
        fmt_b       = 1'b0;
        fmt_u       = 1'b0;
        fmt_j       = 1'b0;
        c_reg_write = 1'b0;
        c_mem_read  = 1'b0;
        c_mem_write = 1'b0;
        c_branch    = 1'b0;
        c_jump      = 1'b0;
        c_alu_imm   = 1'b0;
        case (opcode)
            OP_LOAD: begin
                legal = 1'b1; imm = {{20{if_inst[31]}}, if_inst[31:20]};
                c_reg_write = 1'b1; c_mem_read = 1'b1; c_alu_imm = 1'b1;
            end
            OP_IMM: begin
                legal = 1'b1; imm = {{20{if_inst[31]}}, if_inst[31:20]};
                c_reg_write = 1'b1; c_alu_imm = 1'b1;
            end
            OP_JALR: begin
                legal = 1'b1; imm = {{20{if_inst[31]}}, if_inst[31:20]};
                c_reg_write = 1'b1; c_jump = 1'b1; c_alu_imm = 1'b1;
            end
            OP_STORE: begin
                legal = 1'b1; fmt_s = 1'b1;
                imm = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
                c_mem_write = 1'b1; c_alu_imm = 1'b1;
            end
            OP_BRANCH: begin
                legal = 1'b1; fmt_b = 1'b1;
                imm = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
                c_branch = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                legal = 1'b1; fmt_u = 1'b1; imm = {if_inst[31:12], 12'b0};
                c_reg_write = 1'b1; c_alu_imm = 1'b1;
            end
            OP_JAL: begin
                legal = 1'b1; fmt_j = 1'b1;
                imm = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
                c_reg_write = 1'b1; c_jump = 1'b1;
            end
            OP_REG: begin
                legal = 1'b1; fmt_r = 1'b1; c_reg_write = 1'b1;
            end
            // FENCE and SYSTEM are part of the base set but drive no datapath controls here
            OP_FENCE, OP_SYSTEM: begin
                legal = 1'b1; imm = {{20{if_inst[31]}}, if_inst[31:20]};
            end
            default: legal = 1'b0;
        endcase
    end

    assign rs1_used = !(fmt_u || fmt_j);
    assign rs2_used = fmt_r || fmt_s || fmt_b;

    // Operand read: x0 is hard zero, a same-cycle writeback to the source wins over the stored value
    always_comb begin
        rs1_val = regs[rs1];
        rs2_val = regs[rs2];
        if (wb_we && wb_rd == rs1) rs1_val = wb_data;
        if (wb_we && wb_rd == rs2) rs2_val = wb_data;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    // Load-use hazard against the load in EX; never raised for bubbles, flushes or during reset
    assign stall = reset_n && ex_mem_read && (ex_rd != 5'd0) && !if_dne && !flush &&
                   ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));

    // Architectural register file write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // ID/EX pipeline register: data fields always follow IF/ID, controls priority flush > stall > bubble > illegal > normal
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_pc        <= '0;
            id_rs1       <= '0;
            id_rs2       <= '0;
            id_rd        <= '0;
            id_rs1_val   <= '0;
            id_rs2_val   <= '0;
            id_imm       <= '0;
            id_funct3    <= '0;
            id_funct7    <= '0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_branch    <= 1'b0;
            id_jump      <= 1'b0;
            id_alu_imm   <= 1'b0;
            id_illegal   <= 1'b0;
            id_dne       <= 1'b1;
        end else begin
            id_pc      <= if_pc;
            id_rs1     <= rs1;
            id_rs2     <= rs2;
            id_rd      <= rd;
            id_rs1_val <= rs1_val;
            id_rs2_val <= rs2_val;
            id_imm     <= imm;
            id_funct3  <= if_inst[14:12];
            id_funct7  <= if_inst[31:25];
            if (flush || stall || if_dne || !legal) begin
                id_reg_write <= 1'b0;
                id_mem_read  <= 1'b0;
                id_mem_write <= 1'b0;
                id_branch    <= 1'b0;
                id_jump      <= 1'b0;
                id_alu_imm   <= 1'b0;
                id_illegal   <= !(flush || stall || if_dne);
                id_dne       <= 1'b1;
            end else begin
                id_reg_write <= c_reg_write;
                id_mem_read  <= c_mem_read;
                id_mem_write <= c_mem_write;
                id_branch    <= c_branch;
                id_jump      <= c_jump;
                id_alu_imm   <= c_alu_imm;
                id_illegal   <= 1'b0;
                id_dne       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_unit.sv
// tb/tb_decode_unit.sv - randomized self-checking bench for decode_unit against a behavioural RV32I decode model
module tb_decode_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] if_pc = '0;
    logic [31:0] if_inst = 32'h0050_0093;
    logic        if_dne = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [15:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_imm, id_illegal, id_dne;

    decode_unit #(.PC_W(16), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .if_inst(if_inst), .if_dne(if_dne),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .flush(flush), .stall(stall), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_funct3(id_funct3),
        .id_funct7(id_funct7), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .id_jump(id_jump), .id_alu_imm(id_alu_imm),
        .id_illegal(id_illegal), .id_dne(id_dne)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference architectural state
    int unsigned model_rf [32];

    // Expected values for the cycle being checked
    logic        e_stall, e_dne, e_illegal, e_rw, e_mr, e_mw, e_br, e_jp, e_ai, e_data, e_pc_chk;
    logic [31:0] e_imm, e_v1, e_v2;
    logic [15:0] e_pc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;

    function automatic int unsigned read_reg(input logic [4:0] r);
        if (r == 0) return 0;
        if (wb_we && wb_rd == r) return wb_data;
        return model_rf[r];
    endfunction

    // Decode the current IF/ID inputs from the instruction-set rules
    task automatic calc_expected();
        logic [6:0] op;
        logic is_i, is_ld, is_jalr, is_s, is_b, is_u, is_j, is_r, legal, bubble, use1, use2;
        op = if_inst[6:0];
        is_ld = (op == 7'h03); is_jalr = (op == 7'h67);
        is_i  = (op == 7'h13) || is_ld || is_jalr;
        is_s  = (op == 7'h23); is_b = (op == 7'h63);
        is_u  = (op == 7'h37) || (op == 7'h17); is_j = (op == 7'h6F); is_r = (op == 7'h33);
        legal = is_i || is_s || is_b || is_u || is_j || is_r || op == 7'h0F || op == 7'h73;
        if (is_i)      e_imm = 32'($signed(if_inst[31:20]));
        else if (is_s) e_imm = 32'($signed({if_inst[31:25], if_inst[11:7]}));
        else if (is_b) e_imm = 32'($signed({if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8]})) * 2;
        else if (is_u) e_imm = {if_inst[31:12], 12'h000};
        else if (is_j) e_imm = 32'($signed({if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21]})) * 2;
        else           e_imm = 0;
        e_rs1 = if_inst[19:15]; e_rs2 = if_inst[24:20]; e_rd = if_inst[11:7];
        e_f3 = if_inst[14:12]; e_f7 = if_inst[31:25];
        e_v1 = read_reg(e_rs1); e_v2 = read_reg(e_rs2); e_pc = if_pc;
        use1 = !(is_u || is_j); use2 = is_r || is_s || is_b;
        e_stall = reset_n && ex_mem_read && ex_rd != 0 && !if_dne && !flush &&
                  ((use1 && ex_rd == e_rs1) || (use2 && ex_rd == e_rs2));
        bubble = flush || if_dne || e_stall;
        e_illegal = !bubble && !legal;
        e_dne = bubble || !legal;
        e_rw = !e_dne && (is_r || is_i || is_u || is_j);
        e_mr = !e_dne && is_ld;
        e_mw = !e_dne && is_s;
        e_br = !e_dne && is_b;
        e_jp = !e_dne && (is_j || is_jalr);
        e_ai = !e_dne && (is_i || is_s || is_u);
        e_data = !bubble;
        e_pc_chk = !flush;
        if (!reset_n) begin
            {e_illegal, e_rw, e_mr, e_mw, e_br, e_jp, e_ai} = '0;
            e_dne = 1; e_imm = 0; e_v1 = 0; e_v2 = 0; e_pc = 0;
            e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_f3 = 0; e_f7 = 0;
            e_data = 1; e_pc_chk = 1;
        end
    endtask

    task automatic check_outputs();
        check("id_dne", 32'(id_dne), 32'(e_dne));
        check("id_illegal", 32'(id_illegal), 32'(e_illegal));
        check("id_reg_write", 32'(id_reg_write), 32'(e_rw));
        check("id_mem_read", 32'(id_mem_read), 32'(e_mr));
        check("id_mem_write", 32'(id_mem_write), 32'(e_mw));
        check("id_branch", 32'(id_branch), 32'(e_br));
        check("id_jump", 32'(id_jump), 32'(e_jp));
        check("id_alu_imm", 32'(id_alu_imm), 32'(e_ai));
        if (e_pc_chk) check("id_pc", 32'(id_pc), 32'(e_pc));
        if (e_data) begin
            check("id_rs1", 32'(id_rs1), 32'(e_rs1));
            check("id_rs2", 32'(id_rs2), 32'(e_rs2));
            check("id_rd", 32'(id_rd), 32'(e_rd));
            check("id_rs1_val", id_rs1_val, e_v1);
            check("id_rs2_val", id_rs2_val, e_v2);
            check("id_imm", id_imm, e_imm);
            check("id_funct3", 32'(id_funct3), 32'(e_f3));
            check("id_funct7", 32'(id_funct7), 32'(e_f7));
        end
    endtask

    // Called just after a negedge with inputs driven; checks stall, clocks, checks ID/EX, returns at next negedge
    task automatic do_cycle();
        #1;
        calc_expected();
        check("stall", 32'(stall), 32'(e_stall));
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) model_rf[i] = 0;
        end else if (wb_we && wb_rd != 0) begin
            model_rf[wb_rd] = wb_data;
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] pc, input logic [31:0] inst);
        if_pc = pc; if_inst = inst; if_dne = 0; flush = 0;
        wb_we = 0; ex_mem_read = 0; ex_rd = 0;
    endtask

    logic [6:0] legal_ops [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        for (int i = 0; i < 32; i++) model_rf[i] = 0;

        // Reset held with an ADDI in IF/ID
        @(negedge clk);
        do_cycle();
        do_cycle();
        check("reset_dne", 32'(id_dne), 32'd1);
        reset_n = 1;

        // ADDI x1,x0,5
        drive(16'h0010, 32'h0050_0093);
        do_cycle();
        check("addi_imm", id_imm, 32'd5);
        check("addi_rw", 32'(id_reg_write), 32'd1);

        // Writeback bypass into ADD x3,x2,x0
        drive(16'h0014, 32'h0001_01B3);
        wb_we = 1; wb_rd = 2; wb_data = 32'hDEAD_BEEF;
        do_cycle();
        check("bypass_rs1", id_rs1_val, 32'hDEAD_BEEF);
        drive(16'h0018, 32'h0001_01B3);
        do_cycle();
        check("regfile_x2", id_rs1_val, 32'hDEAD_BEEF);

        // Load-use stall, then release
        drive(16'h001C, 32'h0012_8333);
        ex_mem_read = 1; ex_rd = 5;
        do_cycle();
        check("loaduse_dne", 32'(id_dne), 32'd1);
        ex_mem_read = 0;
        do_cycle();
        check("retry_rw", 32'(id_reg_write), 32'd1);

        // Flush with the same stall conditions
        ex_mem_read = 1; ex_rd = 5; flush = 1;
        do_cycle();
        check("flush_dne", 32'(id_dne), 32'd1);

        // Immediate corner cases
        drive(16'h0020, 32'hFE00_0EE3);
        do_cycle();
        check("beq_imm", id_imm, 32'hFFFF_FFFC);
        drive(16'h0024, 32'h0000_006F);
        do_cycle();
        check("jal_imm", id_imm, 32'h0);
        check("jal_jump", 32'(id_jump), 32'd1);
        drive(16'h0028, 32'hFE11_2E23);
        do_cycle();
        check("sw_imm", id_imm, 32'hFFFF_FFFC);

        // All-zero word and an input bubble
        drive(16'h002C, 32'h0);
        do_cycle();
        check("zero_illegal", 32'(id_illegal), 32'd1);
        drive(16'h0030, 32'h0050_0093);
        if_dne = 1;
        do_cycle();

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            r = $urandom();
            case ($urandom_range(0, 9))
                0: op = 7'h00;
                1: begin
                    do op = 7'($urandom());
                    while (op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h23 || op == 7'h63 ||
                           op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h33 || op == 7'h0F || op == 7'h73);
                end
                default: op = legal_ops[$urandom_range(0, 8)];
            endcase
            if_inst = (op == 7'h00 && r[0]) ? 32'h0 : {r[31:7], op};
            if_pc = 16'($urandom());
            if_dne = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 10);
            wb_we = $urandom_range(0, 1) == 1;
            wb_rd = 5'($urandom());
            if ($urandom_range(0, 3) == 0) wb_rd = if_inst[19:15];
            wb_data = $urandom();
            ex_mem_read = ($urandom_range(0, 99) < 40);
            case ($urandom_range(0, 3))
                0: ex_rd = if_inst[19:15];
                1: ex_rd = if_inst[24:20];
                default: ex_rd = 5'($urandom());
            endcase
            do_cycle();
        end

        // Reset asserted while a stall is pending
        drive(16'h0040, 32'h0012_8333);
        ex_mem_read = 1; ex_rd = 5;
        #1;
        check("pre_reset_stall", 32'(stall), 32'd1);
        reset_n = 0;
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_async_dne", 32'(id_dne), 32'd1);
        check("reset_async_rw", 32'(id_reg_write), 32'd0);
        for (int i = 0; i < 32; i++) model_rf[i] = 0;
        @(negedge clk);
        do_cycle();
        reset_n = 1;
        drive(16'h0044, 32'h0000_83B3);
        do_cycle();
        check("x1_after_reset", id_rs1_val, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
